mips_multicycle_control: RTL and testbench

Main control FSM for the multi-cycle MIPS datapath, sitting directly upstream of the ALU control decoder. It sequences each instruction through fetch/decode/execute/memory/writeback, drives all datapath enables and muxes, and produces the 2-bit alu_op that the ALU control decoder turns into an ALU function. Memory accesses use a ready handshake, so the FSM stalls on slow memory.

---
 rtl/mips_ctrl_pkg.sv | 47 ++++
 rtl/mips_multicycle_control_if.sv | 38 +++
 rtl/mips_ctrl_next_state.sv | 51 +++++
 rtl/mips_multicycle_control.sv | 124 ++++++++++++
 tb/tb_mips_multicycle_control.sv | 172 +++++++++++++++++
 5 files changed

// File: rtl/mips_ctrl_pkg.sv
// Shared constants for the multi-cycle MIPS main control FSM and the ALU control decoder.
// Covers opcodes, state encodings, and the alu_op, alu_src_b and pc_source encodings.
package mips_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    typedef enum logic [3:0] {
        ST_FETCH     = 4'd0,
        ST_DECODE    = 4'd1,
        ST_MEMADR    = 4'd2,
        ST_MEMRD     = 4'd3,
        ST_MEMWB     = 4'd4,
        ST_MEMWR     = 4'd5,
        ST_EXECUTE   = 4'd6,
        ST_ALUWB     = 4'd7,
        ST_BRANCH    = 4'd8,
        ST_ADDIEX    = 4'd9,
        ST_IWB       = 4'd10,
        ST_JUMP      = 4'd11,
        ST_ORIEX     = 4'd12,
        ST_BRANCH_NE = 4'd13,
        ST_UNUSED14  = 4'd14,
        ST_UNUSED15  = 4'd15
    } state_e;

    localparam logic [1:0] ALUOP_RTYPE = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_ADD   = 2'b10;
    localparam logic [1:0] ALUOP_OR    = 2'b11;

    localparam logic [1:0] SRCB_REG    = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMMSH2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/mips_multicycle_control_if.sv
// Control bundle between the main control FSM (master) and the multi-cycle datapath (slave).
interface mips_multicycle_control_if;

    logic [5:0] opcode;
    logic       mem_ready;
    logic       pc_write;
    logic       pc_write_cond;
    logic       pc_write_cond_ne;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic       imm_zext;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       illegal_op;
    logic [3:0] state;

    modport master (
        input  opcode, mem_ready,
        output pc_write, pc_write_cond, pc_write_cond_ne, i_or_d, mem_read, mem_write,
               ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b,
               imm_zext, alu_op, pc_source, illegal_op, state
    );

    modport slave (
        output opcode, mem_ready,
        input  pc_write, pc_write_cond, pc_write_cond_ne, i_or_d, mem_read, mem_write,
               ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b,
               imm_zext, alu_op, pc_source, illegal_op, state
    );

endinterface

// File: rtl/mips_ctrl_next_state.sv
// Combinational next-state function of the main control FSM; stalls in FETCH/MEMRD/MEMWR until mem_ready.
// MIPS_MC_CTRL_BNE_EN adds the DECODE -> BRANCH_NE transition for opcode 0x05.
module mips_ctrl_next_state
    import mips_ctrl_pkg::*;
(
    input  state_e     state_i,
    input  logic [5:0] opcode_i,
    input  logic       mem_ready_i,
    output state_e     next_state_o,
    output logic       illegal_o
);

    always_comb begin
        next_state_o = ST_FETCH;
        illegal_o    = 1'b0;
        case (state_i)
            ST_FETCH:   next_state_o = mem_ready_i ? ST_DECODE : ST_FETCH;
            ST_DECODE: begin
                case (opcode_i)
                    OP_LW, OP_SW: next_state_o = ST_MEMADR;
                    OP_RTYPE:     next_state_o = ST_EXECUTE;
                    OP_BEQ:       next_state_o = ST_BRANCH;
                    OP_ADDI:      next_state_o = ST_ADDIEX;
                    OP_ORI:       next_state_o = ST_ORIEX;
                    OP_J:         next_state_o = ST_JUMP;
`ifdef MIPS_MC_CTRL_BNE_EN
                    OP_BNE:       next_state_o = ST_BRANCH_NE;
`endif
                    default: begin
                        next_state_o = ST_FETCH;
                        illegal_o    = 1'b1;
                    end
                endcase
            end
            // IR still holds the LW/SW opcode here, so it picks the access direction.
            ST_MEMADR:  next_state_o = (opcode_i == OP_LW) ? ST_MEMRD : ST_MEMWR;
            ST_MEMRD:   next_state_o = mem_ready_i ? ST_MEMWB : ST_MEMRD;
            ST_MEMWB:   next_state_o = ST_FETCH;
            ST_MEMWR:   next_state_o = mem_ready_i ? ST_FETCH : ST_MEMWR;
            ST_EXECUTE: next_state_o = ST_ALUWB;
            ST_ALUWB:   next_state_o = ST_FETCH;
            ST_BRANCH:  next_state_o = ST_FETCH;
            ST_ADDIEX:  next_state_o = ST_IWB;
            ST_IWB:     next_state_o = ST_FETCH;
            ST_JUMP:    next_state_o = ST_FETCH;
            ST_ORIEX:   next_state_o = ST_IWB;
            default:    next_state_o = ST_FETCH;
        endcase
    end

endmodule

// File: rtl/mips_multicycle_control.sv
// Multi-cycle MIPS main control: Moore FSM driving datapath enables/muxes and alu_op; stalls on mem_ready.
// MIPS_MC_CTRL_BNE_EN enables the BRANCH_NE state and pc_write_cond_ne; otherwise pc_write_cond_ne is 0.
module mips_multicycle_control
    import mips_ctrl_pkg::*;
(
    input  logic                       clk,
    input  logic                       rst,
    mips_multicycle_control_if.master  ctrl
);

    state_e state_q;
    state_e state_d;
    logic   illegal;

    mips_ctrl_next_state u_next_state (
        .state_i      (state_q),
        .opcode_i     (ctrl.opcode),
        .mem_ready_i  (ctrl.mem_ready),
        .next_state_o (state_d),
        .illegal_o    (illegal)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Outputs are held at zero for the whole reset, including the debug state.
    always_comb begin
        ctrl.pc_write         = 1'b0;
        ctrl.pc_write_cond    = 1'b0;
        ctrl.pc_write_cond_ne = 1'b0;
        ctrl.i_or_d           = 1'b0;
        ctrl.mem_read         = 1'b0;
        ctrl.mem_write        = 1'b0;
        ctrl.ir_write         = 1'b0;
        ctrl.mem_to_reg       = 1'b0;
        ctrl.reg_dst          = 1'b0;
        ctrl.reg_write        = 1'b0;
        ctrl.alu_src_a        = 1'b0;
        ctrl.alu_src_b        = SRCB_REG;
        ctrl.imm_zext         = 1'b0;
        ctrl.alu_op           = ALUOP_RTYPE;
        ctrl.pc_source        = PCSRC_ALU;
        ctrl.illegal_op       = 1'b0;
        ctrl.state            = 4'd0;
        if (!rst) begin
            ctrl.state = state_q;
            case (state_q)
                ST_FETCH: begin
                    ctrl.mem_read  = 1'b1;
                    ctrl.alu_src_b = SRCB_FOUR;
                    ctrl.alu_op    = ALUOP_ADD;
                    ctrl.ir_write  = ctrl.mem_ready;
                    ctrl.pc_write  = ctrl.mem_ready;
                end
                ST_DECODE: begin
                    ctrl.alu_src_b  = SRCB_IMMSH2;
                    ctrl.alu_op     = ALUOP_ADD;
                    ctrl.illegal_op = illegal;
                end
                ST_MEMADR, ST_ADDIEX: begin
                    ctrl.alu_src_a = 1'b1;
                    ctrl.alu_src_b = SRCB_IMM;
                    ctrl.alu_op    = ALUOP_ADD;
                end
                ST_MEMRD: begin
                    ctrl.mem_read = 1'b1;
                    ctrl.i_or_d   = 1'b1;
                end
                ST_MEMWB: begin
                    ctrl.reg_write  = 1'b1;
                    ctrl.mem_to_reg = 1'b1;
                end
                ST_MEMWR: begin
                    ctrl.mem_write = 1'b1;
                    ctrl.i_or_d    = 1'b1;
                end
                ST_EXECUTE: begin
                    ctrl.alu_src_a = 1'b1;
                    ctrl.alu_src_b = SRCB_REG;
                    ctrl.alu_op    = ALUOP_RTYPE;
                end
                ST_ALUWB: begin
                    ctrl.reg_write = 1'b1;
                    ctrl.reg_dst   = 1'b1;
                end
                ST_BRANCH: begin
                    ctrl.alu_src_a     = 1'b1;
                    ctrl.alu_op        = ALUOP_SUB;
                    ctrl.pc_source     = PCSRC_ALUOUT;
                    ctrl.pc_write_cond = 1'b1;
                end
                ST_IWB: begin
                    ctrl.reg_write = 1'b1;
                end
                ST_JUMP: begin
                    ctrl.pc_source = PCSRC_JUMP;
                    ctrl.pc_write  = 1'b1;
                end
                ST_ORIEX: begin
                    ctrl.alu_src_a = 1'b1;
                    ctrl.alu_src_b = SRCB_IMM;
                    ctrl.imm_zext  = 1'b1;
                    ctrl.alu_op    = ALUOP_OR;
                end
`ifdef MIPS_MC_CTRL_BNE_EN
                ST_BRANCH_NE: begin
                    ctrl.alu_src_a        = 1'b1;
                    ctrl.alu_op           = ALUOP_SUB;
                    ctrl.pc_source        = PCSRC_ALUOUT;
                    ctrl.pc_write_cond_ne = 1'b1;
                end
`endif
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Directed bench for mips_multicycle_control: walks each instruction class and checks state and all outputs per cycle.
module tb_mips_multicycle_control;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_pass   = 0;

    always #5 clk = ~clk;

    mips_multicycle_control_if bus();

    mips_multicycle_control dut (
        .clk  (clk),
        .rst  (rst),
        .ctrl (bus)
    );

    // {pc_write, pc_write_cond, pc_write_cond_ne, i_or_d, mem_read, mem_write, ir_write,
    //  mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b[1:0], imm_zext, alu_op[1:0], pc_source[1:0], illegal_op}
    logic [18:0] outs;
    assign outs = {bus.pc_write, bus.pc_write_cond, bus.pc_write_cond_ne, bus.i_or_d,
                   bus.mem_read, bus.mem_write, bus.ir_write, bus.mem_to_reg, bus.reg_dst,
                   bus.reg_write, bus.alu_src_a, bus.alu_src_b, bus.imm_zext, bus.alu_op,
                   bus.pc_source, bus.illegal_op};

    localparam logic [18:0] PCW      = 19'(1) << 18;
    localparam logic [18:0] PCWC     = 19'(1) << 17;
    localparam logic [18:0] PCWCNE   = 19'(1) << 16;
    localparam logic [18:0] IORD     = 19'(1) << 15;
    localparam logic [18:0] MRD      = 19'(1) << 14;
    localparam logic [18:0] MWR      = 19'(1) << 13;
    localparam logic [18:0] IRW      = 19'(1) << 12;
    localparam logic [18:0] M2R      = 19'(1) << 11;
    localparam logic [18:0] RDST     = 19'(1) << 10;
    localparam logic [18:0] RWR      = 19'(1) << 9;
    localparam logic [18:0] SRCA     = 19'(1) << 8;
    localparam logic [18:0] SRCB_4   = 19'(1) << 6;
    localparam logic [18:0] SRCB_IMM = 19'(2) << 6;
    localparam logic [18:0] SRCB_SH  = 19'(3) << 6;
    localparam logic [18:0] ZEXT     = 19'(1) << 5;
    localparam logic [18:0] AOP_SUB  = 19'(1) << 3;
    localparam logic [18:0] AOP_ADD  = 19'(2) << 3;
    localparam logic [18:0] AOP_OR   = 19'(3) << 3;
    localparam logic [18:0] PCS_OUT  = 19'(1) << 1;
    localparam logic [18:0] PCS_J    = 19'(2) << 1;
    localparam logic [18:0] ILL      = 19'(1);

    localparam logic [18:0] X_FETCH   = MRD | SRCB_4 | AOP_ADD | IRW | PCW;
    localparam logic [18:0] X_FSTALL  = MRD | SRCB_4 | AOP_ADD;
    localparam logic [18:0] X_DECODE  = SRCB_SH | AOP_ADD;
    localparam logic [18:0] X_MEMADR  = SRCA | SRCB_IMM | AOP_ADD;
    localparam logic [18:0] X_MEMRD   = MRD | IORD;
    localparam logic [18:0] X_MEMWB   = RWR | M2R;
    localparam logic [18:0] X_MEMWR   = MWR | IORD;
    localparam logic [18:0] X_EXECUTE = SRCA;
    localparam logic [18:0] X_ALUWB   = RWR | RDST;
    localparam logic [18:0] X_BRANCH  = SRCA | AOP_SUB | PCS_OUT | PCWC;
    localparam logic [18:0] X_BRNE    = SRCA | AOP_SUB | PCS_OUT | PCWCNE;
    localparam logic [18:0] X_IWB     = RWR;
    localparam logic [18:0] X_JUMP    = PCS_J | PCW;
    localparam logic [18:0] X_ORIEX   = SRCA | SRCB_IMM | ZEXT | AOP_OR;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // One FSM cycle: apply mem_ready, check state and outputs mid-cycle, advance past the next edge.
    task automatic cyc(input string tag, input logic rdy, input logic [3:0] st, input logic [18:0] ex);
        bus.mem_ready = rdy;
        #1;
        check({tag, ".state"}, 32'(bus.state), 32'(st));
        check({tag, ".outs"}, 32'(outs), 32'(ex));
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst           = 1'b1;
        bus.opcode    = 6'h2B;
        bus.mem_ready = 1'b1;

        @(posedge clk);
        #1;
        cyc("rst0", 1'b1, 4'd0, 19'd0);
        cyc("rst1", 1'b1, 4'd0, 19'd0);
        rst = 1'b0;

        // SW straight out of reset
        cyc("sw.f",  1'b1, 4'd0, X_FETCH);
        cyc("sw.d",  1'b0, 4'd1, X_DECODE);
        cyc("sw.ma", 1'b0, 4'd2, X_MEMADR);
        cyc("sw.wr", 1'b1, 4'd5, X_MEMWR);

        // R-type, mem_ready low in non-memory states must not matter
        bus.opcode = 6'h00;
        cyc("r.f",   1'b1, 4'd0, X_FETCH);
        cyc("r.d",   1'b0, 4'd1, X_DECODE);
        cyc("r.ex",  1'b0, 4'd6, X_EXECUTE);
        cyc("r.wb",  1'b0, 4'd7, X_ALUWB);

        // LW with a fetch stall and two MEMRD stall cycles
        bus.opcode = 6'h23;
        cyc("lw.fs", 1'b0, 4'd0, X_FSTALL);
        cyc("lw.f",  1'b1, 4'd0, X_FETCH);
        cyc("lw.d",  1'b1, 4'd1, X_DECODE);
        cyc("lw.ma", 1'b1, 4'd2, X_MEMADR);
        cyc("lw.r0", 1'b0, 4'd3, X_MEMRD);
        cyc("lw.r1", 1'b0, 4'd3, X_MEMRD);
        cyc("lw.r2", 1'b1, 4'd3, X_MEMRD);
        cyc("lw.wb", 1'b0, 4'd4, X_MEMWB);

        bus.opcode = 6'h04;
        cyc("beq.f", 1'b1, 4'd0, X_FETCH);
        cyc("beq.d", 1'b1, 4'd1, X_DECODE);
        cyc("beq.b", 1'b1, 4'd8, X_BRANCH);

        bus.opcode = 6'h0D;
        cyc("ori.f", 1'b1, 4'd0, X_FETCH);
        cyc("ori.d", 1'b1, 4'd1, X_DECODE);
        cyc("ori.x", 1'b1, 4'd12, X_ORIEX);
        cyc("ori.w", 1'b1, 4'd10, X_IWB);

        bus.opcode = 6'h08;
        cyc("addi.f", 1'b1, 4'd0, X_FETCH);
        cyc("addi.d", 1'b1, 4'd1, X_DECODE);
        cyc("addi.x", 1'b0, 4'd9, X_MEMADR);
        cyc("addi.w", 1'b1, 4'd10, X_IWB);

        bus.opcode = 6'h02;
        cyc("j.f", 1'b1, 4'd0, X_FETCH);
        cyc("j.d", 1'b1, 4'd1, X_DECODE);
        cyc("j.j", 1'b1, 4'd11, X_JUMP);

        // Illegal opcode: one-cycle pulse in DECODE, then back to FETCH
        bus.opcode = 6'h3F;
        cyc("ill.f",  1'b1, 4'd0, X_FETCH);
        cyc("ill.d",  1'b1, 4'd1, X_DECODE | ILL);
        cyc("ill.f2", 1'b0, 4'd0, X_FSTALL);
        cyc("ill.f3", 1'b1, 4'd0, X_FETCH);

        bus.opcode = 6'h05;
`ifdef MIPS_MC_CTRL_BNE_EN
        cyc("bne.d", 1'b1, 4'd1, X_DECODE);
        cyc("bne.b", 1'b1, 4'd13, X_BRNE);
`else
        cyc("bne.d", 1'b1, 4'd1, X_DECODE | ILL);
`endif

        // Reset asserted while MEMWR is stalled
        bus.opcode = 6'h2B;
        cyc("rs.f",  1'b1, 4'd0, X_FETCH);
        cyc("rs.d",  1'b1, 4'd1, X_DECODE);
        cyc("rs.ma", 1'b1, 4'd2, X_MEMADR);
        cyc("rs.wr", 1'b0, 4'd5, X_MEMWR);
        rst = 1'b1;
        cyc("rs.rst", 1'b0, 4'd0, 19'd0);
        rst = 1'b0;
        cyc("rs.f2", 1'b0, 4'd0, X_FSTALL);
        cyc("rs.f3", 1'b1, 4'd0, X_FETCH);
        cyc("rs.d2", 1'b1, 4'd1, X_DECODE);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
